ma_hpf_stream: RTL
==================

# ma_hpf_stream

Streaming moving-average high-pass filter, the complement of the team's moving-average LPF. For each accepted sample it outputs the input minus the running mean of the last ORDER samples, which removes DC and slow drift. It accepts a sample-valid strobe and produces an output-valid strobe, so it can be placed after a decimator or ADC front end that does not deliver a sample every clock.

## Interface
- ORDER, 8, averaging window length in samples; power of two, ≥ 2.
- WIDTH, 16, sample width in bits; two's-complement signed.
- clk_i  input  1  clock; all logic on the rising edge.
- arst_n_i  input  1  asynchronous, active-low reset.
- data_i  input  WIDTH  signed input sample.
- data_val_i  input  1  data_i is valid this cycle and is accepted.
- data_o  output  WIDTH  signed high-pass output sample.
- data_val_o  output  1  data_o is valid this cycle; one-cycle pulse per accepted sample.
- warm_o  output  1  window is filled with ORDER real samples.

## Operation
- One clock domain; reset is asynchronous and active-low.
- While arst_n_i is low, all of the following are 0: data_o, data_val_o, warm_o, the sample buffer, the sum, the write pointer and the fill counter.
- Sample buffer:
  - Circular buffer of ORDER entries × WIDTH bits.
  - Write pointer is log2(ORDER) bits and wraps from ORDER-1 to 0.
  - Oldest entry is read at the write pointer.
- On each accepted sample x, the pipeline does the following:
  - Stage 1: sum ← sum + x − buf[wptr]; buf[wptr] ← x; wptr ← wptr+1; x is registered alongside.
  - Sum width is WIDTH+log2(ORDER), sign-extended, so the sum never overflows.
  - Stage 2: avg = sum >>> log2(ORDER) (arithmetic shift, floor toward −∞); y = x − avg computed at WIDTH+1 bits.
  - y is then saturated or wrapped to WIDTH bits (see Configuration).
- State machine:
  - FILL: entered after reset. Outputs are produced and use the zeros still in the buffer. A fill counter counts accepted samples.
  - FILL → RUN on the ORDER-th accepted sample.
  - RUN: warm_o = 1. The machine stays in RUN until reset.
- If data_val_i is low, no state changes, the pipeline holds its contents, and data_o keeps its last value.
- A one-cycle reset pulse while samples are in flight discards those samples with no output; operation restarts in FILL.

## Timing
- Latency is 2 cycles: data_val_i high at edge n gives data_val_o high after edge n+2, with the matching data_o.
- Throughput is one sample per clock; back-to-back valid inputs are supported with no bubbles.
- data_val_o is a delayed copy of data_val_i and keeps the same gaps.
- warm_o rises together with the data_val_o of the ORDER-th sample.

## Configuration
- MA_HPF_SAT_EN:
  - Defined: y is clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Undefined: y is truncated to its low WIDTH bits (wrap-around).
- All other behaviour is identical in both builds.

## Test plan
Unless stated otherwise, ORDER=8, WIDTH=16, build with MA_HPF_SAT_EN defined.
- Reset: hold arst_n_i low for 3 cycles, then release with no valid input -> data_o=0, data_val_o=0, warm_o=0 on every cycle.
- Constant 800 for 16 consecutive valid cycles -> data_o = 700, 600, 500, 400, 300, 200, 100, 0, then 0 ×8.
  - warm_o rises with the 8th output.
  - Each output appears 2 cycles after its input.
- Warm with −32768 ×8, then input 32767 -> sum = −196609, avg = −24577, y = 57344.
  - With MA_HPF_SAT_EN: output 32767.
  - Without MA_HPF_SAT_EN: output −8192.
- Repeat the constant-800 scenario with data_val_i high only on alternate cycles -> same data_o sequence; data_val_o is alternate-cycle pulses delayed 2 cycles.
- Warm with 800, pulse arst_n_i low for 1 cycle mid-stream, then resume 800 -> data_o, data_val_o and warm_o go to 0 asynchronously; no output for in-flight samples; the output sequence restarts at 700, 600, …

Source files
------------

// File: rtl/ma_hpf_stream_if.sv
// Sample stream bundle for ma_hpf_stream: input sample/strobe, filtered output/strobe, warm flag.
interface ma_hpf_stream_if #(
    parameter int unsigned WIDTH = 16
);
    logic signed [WIDTH-1:0] data_i;
    logic                    data_val_i;
    logic signed [WIDTH-1:0] data_o;
    logic                    data_val_o;
    logic                    warm_o;

    // Upstream source / consumer side
    modport master (
        output data_i,
        output data_val_i,
        input  data_o,
        input  data_val_o,
        input  warm_o
    );

    // Filter side
    modport slave (
        input  data_i,
        input  data_val_i,
        output data_o,
        output data_val_o,
        output warm_o
    );
endinterface

// File: rtl/ma_hpf_stream.sv
// Moving-average high-pass filter: y = x - floor(mean of last ORDER samples), 2-cycle latency.
// Build option MA_HPF_SAT_EN: clamp y to WIDTH bits; otherwise y wraps to its low WIDTH bits.
module ma_hpf_stream #(
    parameter int unsigned ORDER = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic           clk_i,
    input  logic           arst_n_i,
    ma_hpf_stream_if.slave bus
);

    localparam int unsigned LOG2 = $clog2(ORDER);
    localparam int unsigned SW   = WIDTH + LOG2;
    localparam int unsigned YW   = WIDTH + 1;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]              state_q;
    logic [0:0]              state_d;
    logic [LOG2-1:0]         fill_q;
    logic [LOG2-1:0]         fill_d;
    logic [LOG2-1:0]         wptr_q;
    logic signed [WIDTH-1:0] buf_q [ORDER];
    logic signed [SW-1:0]    sum_q;
    logic signed [SW-1:0]    sum_c;
    logic signed [WIDTH-1:0] x_q;
    logic                    val_q;
    logic signed [WIDTH-1:0] avg_c;
    logic signed [YW-1:0]    y_c;
    logic signed [WIDTH-1:0] y_out_c;

    // FSM state register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_FILL;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    // FSM next state: leave FILL on the ORDER-th accepted sample
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        case (state_q)
            ST_FILL: begin
                if (bus.data_val_i) begin
                    fill_d = fill_q + LOG2'(1);
                    if (fill_q == LOG2'(ORDER - 1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // Running sum swaps the oldest sample for the new one; sum is wide enough never to overflow
    always_comb begin
        sum_c = sum_q + SW'(bus.data_i) - SW'(buf_q[wptr_q]);
    end

    // Stage 1: sum, write pointer and the registered copy of x
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sum_q  <= '0;
            wptr_q <= '0;
            x_q    <= '0;
            val_q  <= 1'b0;
        end else begin
            val_q <= bus.data_val_i;
            if (bus.data_val_i) begin
                sum_q  <= sum_c;
                wptr_q <= wptr_q + LOG2'(1);
                x_q    <= bus.data_i;
            end
        end
    end

    // Circular sample buffer; the slot at wptr holds the oldest sample
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < int'(ORDER); i++) begin
                buf_q[i] <= '0;
            end
        end else if (bus.data_val_i) begin
            buf_q[wptr_q] <= bus.data_i;
        end
    end

    // Stage 2 arithmetic: floor mean, difference at WIDTH+1 bits, then narrow
    always_comb begin
        avg_c = WIDTH'(sum_q >>> LOG2);
        y_c   = YW'(x_q) - YW'(avg_c);
`ifdef MA_HPF_SAT_EN
        if (y_c[YW-1] != y_c[WIDTH-1]) begin
            y_out_c = y_c[YW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            y_out_c = WIDTH'(y_c);
        end
`else
        y_out_c = WIDTH'(y_c);
`endif
    end

    // Stage 2 registers: data_o holds its value between valid samples
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            bus.data_o     <= '0;
            bus.data_val_o <= 1'b0;
            bus.warm_o     <= 1'b0;
        end else begin
            bus.data_val_o <= val_q;
            bus.warm_o     <= (state_q == ST_RUN);
            if (val_q) begin
                bus.data_o <= y_out_c;
            end
        end
    end

endmodule
